// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 single-bit mux channel among four requesters.
// Latency: grant/select 1 cycle after req; y/y_vld 1 cycle after gnt/s.
// Backpressure: none; requesters hold req level until served, waiting requests are never dropped.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   req    - per-requester request level
//   i      - per-requester data bit (i[k] belongs to requester k)
//   gnt    - registered one-hot grant
//   s      - registered mux select (index of granted requester)
//   busy   - a grant is active (|gnt)
//   y      - registered mux output
//   y_vld  - y carries valid granted data
//
// Build option: define BURST_LIMIT_EN to cap a grant at MAX_HOLD consecutive
// cycles whenever another requester is waiting. Without it, grants are held
// until the owner drops its request.
module mux_rr_sched #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       y,
  output logic       y_vld
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic [1:0] ptr_q, ptr_d;
  logic       y_q, y_d;
  logic       y_vld_q, y_vld_d;
  logic [1:0] nxt_pick;
  logic       preempt;

  // First requester at or after index p in circular order.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] k;
    pick = p;
    // Walk from the farthest offset back to p so the nearest hit wins.
    for (int n = 3; n >= 0; n--) begin
      k = p + 2'(n);
      if (r[k]) pick = k;
    end
  endfunction

  assign busy     = |gnt_q;
  assign nxt_pick = pick(s_q + 2'd1, req);

`ifdef BURST_LIMIT_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q;

  // Owner has used its share and someone else is waiting.
  assign preempt = (state_q == ST_GRANT) && req[s_q] && (cnt_q == CNT_MAX) &&
                   (|(req & ~gnt_q));

  // Counts cycles of the current grant; restarts whenever ownership changes
  // and saturates so preemption keeps being re-evaluated each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == ST_IDLE) || (gnt_d != gnt_q)) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  // Hold limit has no effect in the non-preemptive build; referenced here so
  // the parameter list stays identical across builds.
  logic [CW-1:0] unused_hold;
  assign unused_hold = CW'(MAX_HOLD - 1);
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          s_d     = pick(ptr_q, req);
          gnt_d   = 4'b0001 << s_d;
          state_d = ST_GRANT;
        end
      end
      default: begin
        // Release or preemption: the departing owner becomes lowest priority.
        if (!req[s_q] || preempt) begin
          ptr_d = s_q + 2'd1;
          if (|req) begin
            // Hand over on the same edge, no idle bubble.
            s_d   = nxt_pick;
            gnt_d = 4'b0001 << nxt_pick;
          end else begin
            // s keeps its last value while idle.
            gnt_d   = 4'b0000;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Datapath stage trails gnt/s by one cycle.
  always_comb begin
    y_d     = busy ? i[s_q] : 1'b0;
    y_vld_d = busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      ptr_q   <= 2'd0;
      y_q     <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign y     = y_q;
  assign y_vld = y_vld_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;
  logic       y;
  logic       y_vld;

  int total;
  int bad;

  mux_rr_sched #(.MAX_HOLD(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i     (i),
    .gnt   (gnt),
    .s     (s),
    .busy  (busy),
    .y     (y),
    .y_vld (y_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; one tick = one rising edge, then sample at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    i     = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst_n = 1'b0;
    req   = 4'b1111;
    i     = 4'b1111;
    tick();
    tick();
    exp = 9'b0;
    total++;
    if ({gnt, s, busy, y, y_vld} !== exp) begin
      bad++;
      $display("FAIL reset: got gnt=%b s=%0d busy=%b y=%b y_vld=%b, want all zero",
               gnt, s, busy, y, y_vld);
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    i     = 4'b0000;
  endtask

  task automatic test_single_grant();
    logic [8:0] exp [4];
    logic [3:0] ivec [4];
    exp[0] = {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0}; ivec[0] = 4'b0100;
    exp[1] = {4'b0100, 2'd2, 1'b1, 1'b1, 1'b1}; ivec[1] = 4'b1011;
    exp[2] = {4'b0100, 2'd2, 1'b1, 1'b0, 1'b1}; ivec[2] = 4'b0100;
    exp[3] = {4'b0100, 2'd2, 1'b1, 1'b1, 1'b1}; ivec[3] = 4'b0100;
    do_reset();
    req = 4'b0100;
    i   = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      tick();
      total++;
      if ({gnt, s, busy, y, y_vld} !== exp[n]) begin
        bad++;
        $display("FAIL single_grant[%0d]: got {gnt,s,busy,y,vld}=%b want %b",
                 n, {gnt, s, busy, y, y_vld}, exp[n]);
      end
      i = ivec[n];
    end
  endtask

  // Continues from test_single_grant: owner 2 holding, i[2]=1.
  task automatic test_release();
    logic [8:0] exp [3];
    exp[0] = {4'b0000, 2'd2, 1'b0, 1'b1, 1'b1};
    exp[1] = {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    exp[2] = {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    req = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if ({gnt, s, busy, y, y_vld} !== exp[n]) begin
        bad++;
        $display("FAIL release[%0d]: got {gnt,s,busy,y,vld}=%b want %b",
                 n, {gnt, s, busy, y, y_vld}, exp[n]);
      end
      i = 4'b1111;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [1:0] own;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      own   = 2'(k % 4);
      exp_g = 4'b0001 << own;
      total++;
      if ({gnt, s, busy} !== {exp_g, own, 1'b1}) begin
        bad++;
        $display("FAIL rotation_first[%0d]: got gnt=%b s=%0d busy=%b want gnt=%b s=%0d busy=1",
                 k, gnt, s, busy, exp_g, own);
      end
      if (k < 4) begin
        req = 4'b1111;
        tick();
        total++;
        if ({gnt, s, busy} !== {exp_g, own, 1'b1}) begin
          bad++;
          $display("FAIL rotation_hold[%0d]: got gnt=%b s=%0d busy=%b want gnt=%b s=%0d busy=1",
                   k, gnt, s, busy, exp_g, own);
        end
        req = 4'b1111 & ~exp_g;
        tick();
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    tick();
    total++;
    if ({gnt, s, busy} !== {4'b1000, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL wrap_setup: got gnt=%b s=%0d busy=%b want gnt=1000 s=3 busy=1", gnt, s, busy);
    end
    req = 4'b0011;
    tick();
    total++;
    if ({gnt, s, busy} !== {4'b0001, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL wrap_to_0: got gnt=%b s=%0d busy=%b want gnt=0001 s=0 busy=1", gnt, s, busy);
    end
    req = 4'b0010;
    tick();
    total++;
    if ({gnt, s, busy} !== {4'b0010, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL wrap_next: got gnt=%b s=%0d busy=%b want gnt=0010 s=1 busy=1", gnt, s, busy);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    // Leave the rotation pointer at 2: serve requester 1, then go idle.
    do_reset();
    req = 4'b0010; tick();
    req = 4'b0000; tick();
    req = 4'b1000;
    i   = 4'b1000;
    tick();
    total++;
    if ({gnt, s, busy} !== {4'b1000, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL midrst_setup: got gnt=%b s=%0d busy=%b want gnt=1000 s=3 busy=1", gnt, s, busy);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({gnt, busy, y, y_vld} !== 7'b0) begin
      bad++;
      $display("FAIL midrst_drop: got gnt=%b busy=%b y=%b y_vld=%b want all zero", gnt, busy, y, y_vld);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({gnt, s, busy} !== {4'b1000, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL midrst_regrant: got gnt=%b s=%0d busy=%b want gnt=1000 s=3 busy=1", gnt, s, busy);
    end
    // Pointer back to 2, then grant 3 via pick(2) with req=1010.
    req = 4'b0000; tick();
    req = 4'b0010; tick();
    req = 4'b0000; tick();
    req = 4'b1010;
    tick();
    total++;
    if ({gnt, s} !== {4'b1000, 2'd3}) begin
      bad++;
      $display("FAIL midrst_ptr_setup: got gnt=%b s=%0d want gnt=1000 s=3", gnt, s);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({gnt, busy, y_vld} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_ptr_drop: got gnt=%b busy=%b y_vld=%b want zero", gnt, busy, y_vld);
    end
    rst_n = 1'b1;
    tick();
    // Pointer restarted at 0, so requester 1 wins over 3.
    total++;
    if ({gnt, s, busy} !== {4'b0010, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL midrst_ptr_restart: got gnt=%b s=%0d busy=%b want gnt=0010 s=1 busy=1", gnt, s, busy);
    end
    req = 4'b0000;
    i   = 4'b0000;
    tick();
  endtask

`ifdef BURST_LIMIT_EN
  task automatic test_burst_limit();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0011;
    tick();
    for (int n = 0; n < 16; n++) begin
      exp_g = (((n / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      total++;
      if (gnt !== exp_g) begin
        bad++;
        $display("FAIL burst_alt[%0d]: got gnt=%b want %b", n, gnt, exp_g);
      end
      tick();
    end
    req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      total++;
      if (gnt !== 4'b0001) begin
        bad++;
        $display("FAIL burst_solo[%0d]: got gnt=%b want 0001", n, gnt);
      end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    i     = 4'b0000;
    @(negedge clk);
    test_reset();
    test_single_grant();
    test_release();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
`ifdef BURST_LIMIT_EN
    test_burst_limit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
